// File: rtl/gcore_sequencer.sv
// rtl/gcore_sequencer.sv - multi-cycle fetch/decode/mem/exec sequencer for the GCore accumulator datapath
// Strobes are decoded combinationally from the state register; a watchdog bounds every memory access.
module gcore_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt_req,
  input  logic [3:0] instr_op,
  input  logic       acc_zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       addr_sel,
  output logic       ir_we,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_we,
  output logic [1:0] acc_src,
  output logic [2:0] alu_op,
  output logic       busy,
  output logic       retire,
  output logic       illegal_op,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_FAULT  = 3'd7
  } state_t;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  state_t          cur;
  logic [TO_W-1:0] to_cnt;
  logic            is_illegal;
  logic            is_nop;
  logic            is_exec;
  logic            is_alu;
  logic            timeout_hit;
  state_t          boundary;

  always_comb begin
    is_illegal  = (instr_op == 4'b0110) || (instr_op == 4'b0111) || (instr_op == 4'b1101);
    is_nop      = (instr_op == 4'b0000) || is_illegal;
    is_exec     = (instr_op == 4'b0100) || (instr_op == 4'b0101);
    is_alu      = instr_op[3] && (instr_op != 4'b1111) && (instr_op != 4'b1101);
    timeout_hit = (MEM_TIMEOUT != 0) && mem_req && !mem_ready && (to_cnt == TO_LIM);
    boundary    = halt_req ? S_IDLE : S_FETCH;
  end

  // The counter only runs while a request is stalled, so it is zero on every FETCH/MEM entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur    <= S_IDLE;
      to_cnt <= '0;
    end else begin
      to_cnt <= (mem_req && !mem_ready) ? to_cnt + 1'b1 : '0;
      case (cur)
        S_IDLE:   if (start) cur <= S_FETCH;
        S_FETCH: begin
          if (mem_ready)        cur <= S_DECODE;
          else if (timeout_hit) cur <= S_FAULT;
        end
        S_DECODE: begin
          if (is_nop)       cur <= boundary;
          else if (is_exec) cur <= S_EXEC;
          else              cur <= S_MEM;
        end
        S_EXEC:   cur <= boundary;
        S_MEM: begin
          if (mem_ready)        cur <= boundary;
          else if (timeout_hit) cur <= S_FAULT;
        end
        S_FAULT:  cur <= S_FAULT;
        default:  cur <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_sel   = 1'b0;
    ir_we      = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    acc_we     = 1'b0;
    acc_src    = 2'b00;
    alu_op     = 3'b000;
    retire     = 1'b0;
    illegal_op = 1'b0;
    state      = cur;
    busy       = (cur != S_IDLE) && (cur != S_FAULT);
    fault      = (cur == S_FAULT);
    case (cur)
      S_FETCH: begin
        mem_req = 1'b1;
        ir_we   = mem_ready;
        pc_inc  = mem_ready;
      end
      S_DECODE: begin
        retire     = is_nop;
        illegal_op = is_illegal;
      end
      S_EXEC: begin
        acc_we  = 1'b1;
        retire  = 1'b1;
        acc_src = (instr_op == 4'b0101) ? 2'b11 : 2'b01;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        mem_we   = (instr_op == 4'b0010);
        if (mem_ready) begin
          retire = 1'b1;
          if (instr_op == 4'b0011) begin
            acc_we = 1'b1;
          end else if (is_alu) begin
            acc_we  = 1'b1;
            acc_src = 2'b10;
            alu_op  = instr_op[2:0];
          end else if (instr_op == 4'b0001) begin
            pc_load = 1'b1;
          end else if (instr_op == 4'b1111) begin
            pc_load = acc_zero;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcore_sequencer.sv
// tb/tb_gcore_sequencer.sv - self-checking bench for gcore_sequencer
// Per-instruction expected strobe sequences are built from the phase rules of each opcode.
module tb_gcore_sequencer;

  logic       clk = 1'b0;
  logic       rst_n, start, halt_req, acc_zero, mem_ready;
  logic [3:0] instr_op;
  logic       mem_req, mem_we, addr_sel, ir_we, pc_inc, pc_load, acc_we;
  logic [1:0] acc_src;
  logic [2:0] alu_op;
  logic       busy, retire, illegal_op, fault;
  logic [2:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  logic       rst_q, start_q, az_q;
  logic [3:0] op_q;
  logic [18:0] obs;
  localparam logic [18:0] ZERO = 19'd0;

  gcore_sequencer #(.MEM_TIMEOUT(15), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .instr_op(instr_op), .acc_zero(acc_zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .addr_sel(addr_sel), .ir_we(ir_we),
    .pc_inc(pc_inc), .pc_load(pc_load), .acc_we(acc_we), .acc_src(acc_src),
    .alu_op(alu_op), .busy(busy), .retire(retire), .illegal_op(illegal_op),
    .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_inc, pc_load, acc_we, acc_src,
                alu_op, busy, retire, illegal_op, fault, state};

  function automatic logic [18:0] v(input logic mreq, mwe, asel, irwe, pinc, pld, awe,
                                    input logic [1:0] src, input logic [2:0] alu,
                                    input logic bsy, ret, ill, flt, input logic [2:0] st);
    return {mreq, mwe, asel, irwe, pinc, pld, awe, src, alu, bsy, ret, ill, flt, st};
  endfunction

  task automatic check(input string name, input logic [18:0] act, input logic [18:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %05h expected %05h", name, act, exp);
    end
  endtask

  task automatic step(input logic rdy, input logic hlt, input logic [18:0] exp, input string name);
    @(negedge clk);
    rst_n = rst_q; start = start_q; instr_op = op_q; acc_zero = az_q;
    mem_ready = rdy; halt_req = hlt;
    #1 check(name, obs, exp);
  endtask

  // Reference: one instruction from its first FETCH cycle to retirement.
  task automatic run_instr(input logic [3:0] op, input int fw, input int mw, input logic az, input logic hlt);
    logic ill, we, ld, alu, pld;
    op_q = op; az_q = az;
    for (int i = 0; i < fw; i++) step(1'b0, hlt, v(1,0,0,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd1), "fetch_wait");
    step(1'b1, hlt, v(1,0,0,1,1,0,0,2'd0,3'd0,1,0,0,0,3'd1), "fetch_rdy");
    ill = (op == 4'd6) || (op == 4'd7) || (op == 4'd13);
    if (op == 4'd0 || ill) begin
      step(1'b0, hlt, v(0,0,0,0,0,0,0,2'd0,3'd0,1,1,ill,0,3'd2), "decode_nop");
    end else begin
      step(1'b0, hlt, v(0,0,0,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd2), "decode");
      if (op == 4'd4 || op == 4'd5) begin
        step(1'b0, hlt, v(0,0,0,0,0,0,1,(op == 4'd4) ? 2'd1 : 2'd3,3'd0,1,1,0,0,3'd4), "exec");
      end else begin
        we  = (op == 4'd2);
        ld  = (op == 4'd3);
        alu = (op >= 4'd8) && (op != 4'd15);
        pld = (op == 4'd1) || (op == 4'd15 && az);
        for (int i = 0; i < mw; i++) step(1'b0, hlt, v(1,we,1,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd3), "mem_wait");
        step(1'b1, hlt, v(1,we,1,0,0,pld,ld || alu,alu ? 2'd2 : 2'd0,alu ? op[2:0] : 3'd0,1,1,0,0,3'd3), "mem_rdy");
      end
    end
    if (hlt) begin
      step(1'b0, 1'b0, ZERO, "halted_idle");
      start_q = 1'b1;
      step(1'b0, 1'b0, ZERO, "restart_idle");
      start_q = 1'b0;
    end
  endtask

  typedef struct {
    logic [3:0] op;
    int         fw;
    int         mw;
    logic       az;
    logic       mwe;
    logic       pld;
    logic       awe;
    logic [1:0] src;
    logic [2:0] alu;
    logic       ill;
    int         lat;
  } vec_t;

  vec_t tab[14];

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int fc, mc, cyc;
    logic got;
    logic [8:0] rv;

    tab[0]  = '{4'h4, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd1, 3'd0, 1'b0, 3};
    tab[1]  = '{4'h5, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd3, 3'd0, 1'b0, 3};
    tab[2]  = '{4'h3, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 3'd0, 1'b0, 6};
    tab[3]  = '{4'h8, 0, 3, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd0, 1'b0, 6};
    tab[4]  = '{4'h9, 2, 1, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd1, 1'b0, 6};
    tab[5]  = '{4'hC, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd4, 1'b0, 3};
    tab[6]  = '{4'hE, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 3'd6, 1'b0, 3};
    tab[7]  = '{4'hF, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 3};
    tab[8]  = '{4'hF, 0, 0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 3};
    tab[9]  = '{4'h1, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 3'd0, 1'b0, 3};
    tab[10] = '{4'h2, 0, 2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 5};
    tab[11] = '{4'h7, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 2};
    tab[12] = '{4'hD, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b1, 2};
    tab[13] = '{4'h0, 1, 0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 3'd0, 1'b0, 3};

    rst_q = 1'b0; start_q = 1'b1; op_q = 4'h0; az_q = 1'b0;
    rst_n = 1'b0; start = 1'b1; instr_op = 4'h0; acc_zero = 1'b0; mem_ready = 1'b0; halt_req = 1'b0;

    step(1'b0, 1'b0, ZERO, "reset0");
    step(1'b0, 1'b0, ZERO, "reset1");
    rst_q = 1'b1;
    step(1'b0, 1'b0, ZERO, "release_idle");
    start_q = 1'b0;
    run_instr(4'h4, 0, 0, 1'b0, 1'b0);
    run_instr(4'h5, 0, 0, 1'b0, 1'b0);

    // Table: observe only the retirement cycle and the total latency.
    for (int k = 0; k < 14; k++) begin
      op_q = tab[k].op; az_q = tab[k].az;
      fc = 0; mc = 0; cyc = 0; got = 1'b0; rv = '0;
      while (!got && cyc < 40) begin
        @(negedge clk);
        rst_n = rst_q; start = start_q; instr_op = op_q; acc_zero = az_q; halt_req = 1'b0;
        mem_ready = (state == 3'd1) ? (fc >= tab[k].fw) : (state == 3'd3) ? (mc >= tab[k].mw) : 1'b0;
        if (state == 3'd1) fc++;
        if (state == 3'd3) mc++;
        #1 cyc++;
        if (retire) begin
          got = 1'b1;
          rv = {mem_we, pc_load, acc_we, acc_src, alu_op, illegal_op};
        end
      end
      n_tests++;
      if (!got || cyc != tab[k].lat) begin
        n_fail++;
        $display("FAIL tab%0d_latency: got %0d cycles (retired=%0b) expected %0d", k, cyc, got, tab[k].lat);
      end
      n_tests++;
      if (rv !== {tab[k].mwe, tab[k].pld, tab[k].awe, tab[k].src, tab[k].alu, tab[k].ill}) begin
        n_fail++;
        $display("FAIL tab%0d_retire_strobes: got %03h expected %03h", k, rv,
                 {tab[k].mwe, tab[k].pld, tab[k].awe, tab[k].src, tab[k].alu, tab[k].ill});
      end
    end

    run_instr(4'h7, 0, 0, 1'b0, 1'b0);
    run_instr(4'h3, 0, 3, 1'b0, 1'b1);
    run_instr(4'h0, 0, 0, 1'b0, 1'b1);

    for (int n = 0; n < 60; n++) begin
      run_instr(4'($urandom_range(0, 15)), $urandom_range(0, 4), $urandom_range(0, 4),
                1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0));
    end

    run_instr(4'h0, 15, 0, 1'b0, 1'b0);
    run_instr(4'h3, 0, 15, 1'b0, 1'b0);
    run_instr(4'hB, 15, 15, 1'b0, 1'b0);

    op_q = 4'h3;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, v(1,0,0,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd1), "wd_wait");
    start_q = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v(0,0,0,0,0,0,0,2'd0,3'd0,0,0,0,1,3'd7), "fault_hold");
    rst_q = 1'b0;
    step(1'b0, 1'b0, v(0,0,0,0,0,0,0,2'd0,3'd0,0,0,0,1,3'd7), "fault_rst_edge");
    step(1'b0, 1'b0, ZERO, "fault_reset");
    rst_q = 1'b1;
    step(1'b0, 1'b0, ZERO, "fault_restart");
    start_q = 1'b0;
    run_instr(4'h0, 0, 0, 1'b0, 1'b0);

    op_q = 4'h3;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, v(1,0,0,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd1), "abort_wait");
    rst_q = 1'b0;
    step(1'b0, 1'b0, v(1,0,0,0,0,0,0,2'd0,3'd0,1,0,0,0,3'd1), "abort_rst_edge");
    step(1'b1, 1'b0, ZERO, "abort_reset");
    rst_q = 1'b1;
    step(1'b1, 1'b0, ZERO, "abort_idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
